cache_line_mover: RTL and testbench

Memory-side miss engine for the direct-mapped 4-column cache. On a miss it writes a dirty victim line back to backing memory as a 4-beat burst, fetches the missed line as a 4-beat burst, and writes the data words plus tag (valid=1, dirty=0) into the cache's tag/data block RAMs. It sits between the cache RAM ports and the burst memory controller.

---
 rtl/cache_pkg.sv | 34 +++
 rtl/cache_line_buffer.sv | 37 +++
 rtl/cache_line_mover.sv | 209 ++++++++++++++++++++
 tb/tb_cache_line_mover.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg
// Shared definitions for the direct-mapped 4-column cache and its miss engine.
// Address layout (32 bits): {tag, line index, column index (2), byte-in-word (2)}.
// Tag RAM entry layout: {dirty, valid, tag}, with the two status bits sitting
// directly above the tag field at the offsets given below.
package cache_pkg;

  localparam int ADDRESS_BITWIDTH   = 32;
  localparam int WORD_BITWIDTH      = 32;
  localparam int ZEROS_BITWIDTH     = 2;
  localparam int COLUMN_IX_BITWIDTH = 2;
  localparam int COLUMN_COUNT       = 4;
  localparam int OFFSET_BITWIDTH    = ZEROS_BITWIDTH + COLUMN_IX_BITWIDTH;

  // Status bit positions relative to the first bit above the tag field.
  localparam int VALID_BIT_OFFSET = 0;
  localparam int DIRTY_BIT_OFFSET = 1;

  // Tag width left over once the line index and line offset are removed.
  function automatic int tag_bitwidth(input int line_ix_bitwidth);
    return ADDRESS_BITWIDTH - line_ix_bitwidth - OFFSET_BITWIDTH;
  endfunction

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ_LINE = 3'd1,
    WB_CMD    = 3'd2,
    WB_DATA   = 3'd3,
    FILL_CMD  = 3'd4,
    FILL_DATA = 3'd5,
    DONE      = 3'd6
  } mover_state_t;

endpackage

// File: rtl/cache_line_buffer.sv
// cache_line_buffer
// Holds one cache line (4 x 32-bit words) while it is being written back.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   write_enable  - store write_data into word write_column
//   write_column  - word slot written
//   write_data    - word to store
//   read_beat     - word slot presented on read_data
//   read_data     - combinational read of slot read_beat
module cache_line_buffer
  import cache_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          write_enable,
  input  logic [COLUMN_IX_BITWIDTH-1:0] write_column,
  input  logic [WORD_BITWIDTH-1:0]      write_data,
  input  logic [COLUMN_IX_BITWIDTH-1:0] read_beat,
  output logic [WORD_BITWIDTH-1:0]      read_data
);

  logic [WORD_BITWIDTH-1:0] words [COLUMN_COUNT];

  // Register file: one write port addressed by column.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < COLUMN_COUNT; i++) begin
        words[i] <= '0;
      end
    end else if (write_enable) begin
      words[write_column] <= write_data;
    end
  end

  assign read_data = words[read_beat];

endmodule

// File: rtl/cache_line_mover.sv
// cache_line_mover
// Miss engine between the cache tag/data RAMs and a burst memory controller.
// On an accepted miss it optionally copies the dirty victim line out of the
// data RAM and writes it back as a 4-beat burst, then fetches the missed line
// as a 4-beat burst and writes each word into the data RAM, marking the tag
// entry valid and clean together with the last word.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   miss_valid, miss_address          - miss request (sampled only in IDLE)
//   victim_dirty, victim_tag          - state of the line being replaced
//   busy, done                        - operation in progress / line installed
//   line_ix, column_ix                - cache RAM address
//   line_read_data                    - data RAM output (1-cycle latency)
//   line_write_data, line_write_enable, tag_write - cache RAM write side
//   mem_address, mem_cmd_*            - burst command handshake
//   mem_wdata*                        - write-burst beats
//   mem_rdata, mem_rdata_valid        - read-burst beats, no backpressure
// Every output is a register, so RAM writes appear the cycle after the beat
// that carried them.
module cache_line_mover
  import cache_pkg::*;
#(
  parameter int LINE_IX_BITWIDTH = 8,
  parameter int TAG_BITWIDTH     = tag_bitwidth(LINE_IX_BITWIDTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss_valid,
  input  logic [ADDRESS_BITWIDTH-1:0]   miss_address,
  input  logic                          victim_dirty,
  input  logic [TAG_BITWIDTH-1:0]       victim_tag,
  output logic                          busy,
  output logic                          done,
  output logic [LINE_IX_BITWIDTH-1:0]   line_ix,
  output logic [COLUMN_IX_BITWIDTH-1:0] column_ix,
  input  logic [WORD_BITWIDTH-1:0]      line_read_data,
  output logic [WORD_BITWIDTH-1:0]      line_write_data,
  output logic [3:0]                    line_write_enable,
  output logic                          tag_write,
  output logic [ADDRESS_BITWIDTH-1:0]   mem_address,
  output logic                          mem_cmd_valid,
  input  logic                          mem_cmd_ready,
  output logic                          mem_cmd_write,
  output logic [WORD_BITWIDTH-1:0]      mem_wdata,
  output logic                          mem_wdata_valid,
  input  logic                          mem_wdata_ready,
  input  logic [WORD_BITWIDTH-1:0]      mem_rdata,
  input  logic                          mem_rdata_valid
);

  mover_state_t                  state;
  logic [TAG_BITWIDTH-1:0]       miss_tag;
  logic [TAG_BITWIDTH-1:0]       wb_tag;
  logic [COLUMN_IX_BITWIDTH-1:0] beat;
  logic [2:0]                    read_step;

  logic                          buf_write_enable;
  logic [COLUMN_IX_BITWIDTH-1:0] buf_write_column;
  logic [COLUMN_IX_BITWIDTH-1:0] buf_read_beat;
  logic [WORD_BITWIDTH-1:0]      buf_read_data;
  logic                          unused_offset;

  // The byte/column offset of the miss address never matters: whole lines move.
  assign unused_offset = ^miss_address[OFFSET_BITWIDTH-1:0];

  // READ_LINE issues column k at step k and sees its data at step k+1, so
  // steps 1..4 capture columns 0..3 (step 4 wraps 3'b100 -> column 2'b11).
  assign buf_write_enable = (state == READ_LINE) && (read_step != 3'd0);
  assign buf_write_column = read_step[COLUMN_IX_BITWIDTH-1:0] - 2'd1;

  // mem_wdata is registered, so the buffer is read one beat ahead: word 0
  // while the command is pending, beat+1 while a burst is running.
  assign buf_read_beat = (state == WB_DATA) ? beat + 2'd1 : 2'd0;

  cache_line_buffer u_line_buffer (
    .clk          (clk),
    .rst          (rst),
    .write_enable (buf_write_enable),
    .write_column (buf_write_column),
    .write_data   (line_read_data),
    .read_beat    (buf_read_beat),
    .read_data    (buf_read_data)
  );

  // Whole operation sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      miss_tag          <= '0;
      wb_tag            <= '0;
      beat              <= '0;
      read_step         <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      line_ix           <= '0;
      column_ix         <= '0;
      line_write_data   <= '0;
      line_write_enable <= 4'b0000;
      tag_write         <= 1'b0;
      mem_address       <= '0;
      mem_cmd_valid     <= 1'b0;
      mem_cmd_write     <= 1'b0;
      mem_wdata         <= '0;
      mem_wdata_valid   <= 1'b0;
    end else begin
      done              <= 1'b0;
      line_write_enable <= 4'b0000;
      tag_write         <= 1'b0;

      case (state)
        IDLE: begin
          if (miss_valid) begin
            line_ix  <= miss_address[OFFSET_BITWIDTH +: LINE_IX_BITWIDTH];
            miss_tag <= miss_address[ADDRESS_BITWIDTH-1 -: TAG_BITWIDTH];
            wb_tag   <= victim_tag;
            busy     <= 1'b1;
            beat     <= '0;
            if (victim_dirty) begin
              state     <= READ_LINE;
              read_step <= '0;
              column_ix <= '0;
            end else begin
              state         <= FILL_CMD;
              mem_cmd_valid <= 1'b1;
              mem_cmd_write <= 1'b0;
              mem_address   <= {miss_address[ADDRESS_BITWIDTH-1:OFFSET_BITWIDTH],
                                {OFFSET_BITWIDTH{1'b0}}};
            end
          end
        end

        READ_LINE: begin
          read_step <= read_step + 3'd1;
          if (read_step < 3'd3) begin
            column_ix <= read_step[COLUMN_IX_BITWIDTH-1:0] + 2'd1;
          end
          if (read_step == 3'd4) begin
            state         <= WB_CMD;
            read_step     <= '0;
            column_ix     <= '0;
            mem_cmd_valid <= 1'b1;
            mem_cmd_write <= 1'b1;
            mem_address   <= {wb_tag, line_ix, {OFFSET_BITWIDTH{1'b0}}};
          end
        end

        WB_CMD: begin
          if (mem_cmd_ready) begin
            state           <= WB_DATA;
            mem_cmd_valid   <= 1'b0;
            mem_cmd_write   <= 1'b0;
            beat            <= '0;
            mem_wdata       <= buf_read_data;
            mem_wdata_valid <= 1'b1;
          end
        end

        WB_DATA: begin
          if (mem_wdata_ready) begin
            beat <= beat + 2'd1;
            if (beat == 2'd3) begin
              state           <= FILL_CMD;
              mem_wdata_valid <= 1'b0;
              mem_wdata       <= '0;
              mem_cmd_valid   <= 1'b1;
              mem_cmd_write   <= 1'b0;
              mem_address     <= {miss_tag, line_ix, {OFFSET_BITWIDTH{1'b0}}};
            end else begin
              mem_wdata <= buf_read_data;
            end
          end
        end

        FILL_CMD: begin
          if (mem_cmd_ready) begin
            state         <= FILL_DATA;
            mem_cmd_valid <= 1'b0;
            beat          <= '0;
          end
        end

        FILL_DATA: begin
          if (mem_rdata_valid) begin
            line_write_data   <= mem_rdata;
            line_write_enable <= 4'b1111;
            column_ix         <= beat;
            beat              <= beat + 2'd1;
            if (beat == 2'd3) begin
              state     <= DONE;
              tag_write <= 1'b1;
              done      <= 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_mover.sv
// tb_cache_line_mover
// Drives the miss engine against a behavioural cache data RAM and a burst
// memory controller. The reference model states the outcome of a miss directly:
// the cache line becomes the memory contents of the missed line, a dirty
// victim's old contents land in memory at the victim address, and the RAM sees
// exactly four writes (columns 0..3) with the tag write on the last one.
module tb_cache_line_mover;
  import cache_pkg::*;

  localparam int LW = 8;
  localparam int TW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_valid;
  logic [31:0]   miss_address;
  logic          victim_dirty;
  logic [TW-1:0] victim_tag;
  logic          busy;
  logic          done;
  logic [LW-1:0] line_ix;
  logic [1:0]    column_ix;
  logic [31:0]   line_read_data;
  logic [31:0]   line_write_data;
  logic [3:0]    line_write_enable;
  logic          tag_write;
  logic [31:0]   mem_address;
  logic          mem_cmd_valid;
  logic          mem_cmd_ready;
  logic          mem_cmd_write;
  logic [31:0]   mem_wdata;
  logic          mem_wdata_valid;
  logic          mem_wdata_ready;
  logic [31:0]   mem_rdata;
  logic          mem_rdata_valid;

  always #5 clk = ~clk;

  cache_line_mover #(.LINE_IX_BITWIDTH(LW)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_valid        (miss_valid),
    .miss_address      (miss_address),
    .victim_dirty      (victim_dirty),
    .victim_tag        (victim_tag),
    .busy              (busy),
    .done              (done),
    .line_ix           (line_ix),
    .column_ix         (column_ix),
    .line_read_data    (line_read_data),
    .line_write_data   (line_write_data),
    .line_write_enable (line_write_enable),
    .tag_write         (tag_write),
    .mem_address       (mem_address),
    .mem_cmd_valid     (mem_cmd_valid),
    .mem_cmd_ready     (mem_cmd_ready),
    .mem_cmd_write     (mem_cmd_write),
    .mem_wdata         (mem_wdata),
    .mem_wdata_valid   (mem_wdata_valid),
    .mem_wdata_ready   (mem_wdata_ready),
    .mem_rdata         (mem_rdata),
    .mem_rdata_valid   (mem_rdata_valid)
  );

  logic [115:0] all_outputs;
  assign all_outputs = {busy, done, line_ix, column_ix, line_write_data, line_write_enable,
                        tag_write, mem_address, mem_cmd_valid, mem_cmd_write, mem_wdata,
                        mem_wdata_valid};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural storage: cache data RAM and backing memory.
  logic [31:0] cache_data [0:255][0:3];
  logic [31:0] mem [int unsigned];
  logic        tag_status [0:255][0:1];

  function automatic logic [31:0] mem_value(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  // Data RAM read port with one cycle of latency.
  always @(posedge clk) line_read_data <= cache_data[line_ix][column_ix];

  // Controller knobs and logs shared with the stimulus.
  int          cmd_pct = 100;
  int          wr_pct = 100;
  int          rd_pct = 100;
  bit          noise = 1'b0;
  bit          wready_pat [$];
  bit          rvalid_pat [$];
  logic [32:0] cmd_log [$];
  logic [31:0] wb_log [$];
  logic [1:0]  wr_cols [$];
  logic [31:0] stall_words [$];
  int          wr_count = 0;
  int          tag_count = 0;
  int          tag_good = 0;
  int          bad_we = 0;
  int          stall_viol = 0;
  int          done_count = 0;
  logic [LW-1:0] tag_line;
  int          ctrl_mode = 0;
  int          ctrl_beat = 0;
  logic [31:0] ctrl_addr;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_wdata;
  bit          go;

  // Memory controller and RAM write port. Runs just after the falling edge,
  // deciding the inputs for the coming rising edge from the current outputs.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      ctrl_mode       = 0;
      ctrl_beat       = 0;
      prev_stall      = 1'b0;
      mem_cmd_ready   = 1'b0;
      mem_wdata_ready = 1'b0;
      mem_rdata_valid = 1'b0;
      mem_rdata       = '0;
    end else begin
      if (line_write_enable != 4'b0000) begin
        if (line_write_enable != 4'b1111) bad_we++;
        cache_data[line_ix][column_ix] = line_write_data;
        wr_cols.push_back(column_ix);
        wr_count++;
      end
      if (tag_write) begin
        tag_count++;
        if (line_write_enable == 4'b1111 && column_ix == 2'd3) tag_good++;
        tag_line = line_ix;
        tag_status[line_ix][VALID_BIT_OFFSET] = 1'b1;
        tag_status[line_ix][DIRTY_BIT_OFFSET] = 1'b0;
      end
      if (done) done_count++;

      mem_rdata_valid = 1'b0;
      if (ctrl_mode == 2) begin
        if (rvalid_pat.size() > 0) go = rvalid_pat.pop_front();
        else go = ($urandom_range(1, 100) <= rd_pct);
        if (go) begin
          mem_rdata_valid = 1'b1;
          mem_rdata = mem_value(ctrl_addr + 32'(4 * ctrl_beat));
          ctrl_beat++;
          if (ctrl_beat == 4) ctrl_mode = 0;
        end
      end else if (noise) begin
        mem_rdata_valid = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end

      mem_wdata_ready = 1'b0;
      if (ctrl_mode == 1 && mem_wdata_valid) begin
        if (prev_stall && mem_wdata !== prev_wdata) stall_viol++;
        if (wready_pat.size() > 0) go = wready_pat.pop_front();
        else go = ($urandom_range(1, 100) <= wr_pct);
        if (go) begin
          mem[ctrl_addr + 32'(4 * ctrl_beat)] = mem_wdata;
          wb_log.push_back(mem_wdata);
          ctrl_beat++;
          if (ctrl_beat == 4) ctrl_mode = 0;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_wdata = mem_wdata;
          stall_words.push_back(mem_wdata);
        end
        mem_wdata_ready = go;
      end else if (noise) begin
        mem_wdata_ready = 1'($urandom_range(0, 1));
      end

      mem_cmd_ready = 1'b0;
      if (ctrl_mode == 0 && mem_cmd_valid) begin
        if ($urandom_range(1, 100) <= cmd_pct) begin
          mem_cmd_ready = 1'b1;
          cmd_log.push_back({mem_cmd_write, mem_address});
          ctrl_mode = mem_cmd_write ? 1 : 2;
          ctrl_beat = 0;
          ctrl_addr = mem_address;
        end
      end else if (noise && !mem_cmd_valid) begin
        mem_cmd_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete miss, followed by comparison against the outcome model.
  // exp_latency = 0 skips the cycle-exact done check.
  task automatic applyStimulus(input bit dirty, input logic [31:0] addr, input logic [TW-1:0] vtag,
                               input bit spurious, input int exp_latency);
    logic [LW-1:0] idx;
    logic [TW-1:0] mtag;
    logic [31:0]   old_line [4];
    logic [31:0]   exp_fill [4];
    logic [7:0]    cols_packed;
    int            start, done_at, wr0, tag0, good0, done0, viol0, badwe0;
    bit            got;
    idx  = addr[11:4];
    mtag = addr[31:12];
    for (int c = 0; c < 4; c++) begin
      old_line[c] = cache_data[idx][c];
      exp_fill[c] = mem_value({mtag, idx, 2'(c), 2'b00});
    end
    cmd_log.delete();
    wb_log.delete();
    wr_cols.delete();
    stall_words.delete();
    wr0 = wr_count; tag0 = tag_count; good0 = tag_good; done0 = done_count;
    viol0 = stall_viol; badwe0 = bad_we;
    tag_status[idx][VALID_BIT_OFFSET] = 1'b0;

    @(negedge clk);
    miss_valid = 1'b1; miss_address = addr; victim_dirty = dirty; victim_tag = vtag;
    start = cyc;
    @(negedge clk);
    miss_valid = 1'b0;
    checkOutput("busy_after_accept", busy, 1);

    got = 1'b0;
    done_at = 0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        got = 1'b1;
        done_at = cyc;
        if (spurious) miss_valid = 1'b1;
        break;
      end
      @(negedge clk);
      if (spurious) begin
        miss_valid = 1'($urandom_range(0, 1));
        miss_address = $urandom;
        victim_dirty = 1'($urandom_range(0, 1));
        victim_tag = TW'($urandom);
      end
    end
    @(negedge clk);
    miss_valid = 1'b0; victim_dirty = 1'b0;
    checkOutput("done_seen", got, 1);
    checkOutput("busy_cleared", {busy, mem_cmd_valid}, 0);
    if (exp_latency > 0) checkOutput("done_latency", done_at - start, exp_latency);
    repeat (2) @(negedge clk);
    checkOutput("done_pulses", done_count - done0, 1);
    checkOutput("ram_write_count", wr_count - wr0, 4);
    cols_packed = '0;
    foreach (wr_cols[k]) cols_packed = {cols_packed[5:0], wr_cols[k]};
    checkOutput("column_order", cols_packed, 8'h1B);
    checkOutput("tag_write_count", tag_count - tag0, 1);
    checkOutput("tag_with_col3", tag_good - good0, 1);
    checkOutput("tag_line", tag_line, idx);
    checkOutput("tag_status", {tag_status[idx][DIRTY_BIT_OFFSET], tag_status[idx][VALID_BIT_OFFSET]}, 2'b01);
    for (int c = 0; c < 4; c++) checkOutput("line_data", cache_data[idx][c], exp_fill[c]);
    checkOutput("cmd_count", cmd_log.size(), dirty ? 2 : 1);
    if (dirty && cmd_log.size() == 2) begin
      checkOutput("wb_cmd", cmd_log[0], {1'b1, vtag, idx, 4'h0});
      checkOutput("fill_cmd", cmd_log[1], {1'b0, mtag, idx, 4'h0});
    end else if (!dirty && cmd_log.size() == 1) begin
      checkOutput("fill_cmd", cmd_log[0], {1'b0, mtag, idx, 4'h0});
    end
    checkOutput("wb_beats", wb_log.size(), dirty ? 4 : 0);
    if (dirty && wb_log.size() == 4) begin
      for (int c = 0; c < 4; c++) checkOutput("wb_data", wb_log[c], old_line[c]);
    end
    checkOutput("stall_hold", stall_viol - viol0, 0);
    checkOutput("write_enable_form", bad_we - badwe0, 0);
  endtask

  initial begin
    int wr0;
    int tag0;
    bit got;
    logic [31:0] a;
    logic [TW-1:0] vt;

    rst = 1'b1; miss_valid = 1'b0; miss_address = '0; victim_dirty = 1'b0; victim_tag = '0;
    mem_cmd_ready = 1'b0; mem_wdata_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      tag_status[i][0] = 1'b0;
      tag_status[i][1] = 1'b0;
      for (int c = 0; c < 4; c++) cache_data[i][c] = $urandom;
    end
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", all_outputs, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_reset", {busy, done, mem_cmd_valid}, 0);

    $display("[TB] clean miss, zero-wait memory");
    mem[32'h1230] = 32'hA0; mem[32'h1234] = 32'hA1; mem[32'h1238] = 32'hA2; mem[32'h123C] = 32'hA3;
    applyStimulus(1'b0, 32'h0000_1234, 20'h0, 1'b0, 6);

    $display("[TB] dirty miss, write-back then fill");
    for (int c = 0; c < 4; c++) cache_data[8'h23][c] = 32'hB0 + 32'(c);
    applyStimulus(1'b1, 32'h0004_5238, 20'h00001, 1'b0, 16);
    checkOutput("wb_in_memory", mem_value(32'h1234), 32'hB1);

    $display("[TB] write-back stalled three cycles on beat 1");
    for (int c = 0; c < 4; c++) cache_data[8'h23][c] = 32'hB0 + 32'(c);
    wready_pat = '{1'b1, 1'b0, 1'b0, 1'b0};
    applyStimulus(1'b1, 32'h0000_1230, 20'h00009, 1'b0, 19);
    checkOutput("stall_cycles", stall_words.size(), 3);
    foreach (stall_words[k]) checkOutput("stall_word", stall_words[k], 32'hB1);

    $display("[TB] read beats with gaps");
    rvalid_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    applyStimulus(1'b0, 32'h0123_4560, 20'h0, 1'b0, 8);

    $display("[TB] reset during write-back beat 2");
    wready_pat.delete(); rvalid_pat.delete();
    wr0 = wr_count; tag0 = tag_count;
    wb_log.delete();
    @(negedge clk);
    miss_valid = 1'b1; miss_address = 32'h0007_75A0; victim_dirty = 1'b1; victim_tag = 20'h00099;
    @(negedge clk);
    miss_valid = 1'b0; victim_dirty = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (mem_wdata_valid && wb_log.size() == 2) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("reached_beat2", got, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_mid_outputs", all_outputs, 0);
    rst = 1'b0;
    checkOutput("reset_no_ram_write", wr_count - wr0, 0);
    checkOutput("reset_no_tag_write", tag_count - tag0, 0);
    repeat (3) @(negedge clk);
    checkOutput("reset_stays_idle", {busy, mem_cmd_valid, mem_wdata_valid}, 0);
    checkOutput("reset_wb_abandoned", wb_log.size(), 2);
    applyStimulus(1'b1, 32'h0007_75A0, 20'h00099, 1'b0, 16);

    $display("[TB] miss_valid pulses while busy and on done");
    applyStimulus(1'b1, 32'h00AB_C120, 20'h00777, 1'b1, 16);
    repeat (3) @(negedge clk);
    checkOutput("spurious_not_accepted", {busy, mem_cmd_valid}, 0);

    $display("[TB] randomized misses");
    noise = 1'b1;
    for (int n = 0; n < 20; n++) begin
      cmd_pct = $urandom_range(30, 100);
      wr_pct  = $urandom_range(30, 100);
      rd_pct  = $urandom_range(30, 100);
      a  = $urandom;
      vt = TW'($urandom);
      if (vt == a[31:12]) vt = ~vt;
      applyStimulus(1'($urandom_range(0, 1)), a, vt, 1'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
